// File: rtl/common_bus_pkg.sv
// Shared constants and types for the common bus arbiter.
// Source select codes match the bus multiplexer inputs.
package common_bus_pkg;

  localparam int N_SRC = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  localparam logic [SEL_W-1:0] SRC_0 = 3'd0;
  localparam logic [SEL_W-1:0] SRC_1 = 3'd1;
  localparam logic [SEL_W-1:0] SRC_2 = 3'd2;
  localparam logic [SEL_W-1:0] SRC_3 = 3'd3;
  localparam logic [SEL_W-1:0] SRC_4 = 3'd4;
  localparam logic [SEL_W-1:0] SRC_5 = 3'd5;
  localparam logic [SEL_W-1:0] SRC_6 = 3'd6;
  localparam logic [SEL_W-1:0] SRC_7 = 3'd7;

  function automatic logic [N_SRC-1:0] sel2onehot(
    input logic [SEL_W-1:0] s
  );
    logic [N_SRC-1:0] v;
    v = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit
// at or after start, wrapping 7 -> 0.
module rr_pick
  import common_bus_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0] w_cand;

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx    = '0;
    found  = 1'b0;
    w_cand = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      w_cand = start + SEL_W'(i);
      if (req[w_cand]) begin
        idx   = w_cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/common_bus_arbiter.sv
// Round-robin owner arbiter for the 8-source common bus
// with a per-grant hold limit.
module common_bus_arbiter
  import common_bus_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req,
  output logic [N_SRC-1:0] grant,
  output logic [SEL_W-1:0] bus_sel,
  output logic             bus_valid,
  output logic             hold_expired
);

  localparam int CW = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

  state_e           r_state;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] r_sel;
  logic [CW-1:0]    r_hold_cnt;
  logic [N_SRC-1:0] r_grant;
  logic             r_valid;
  logic             r_exp;

  logic [SEL_W-1:0] w_start;
  logic [SEL_W-1:0] w_idx;
  logic             w_found;
  logic             w_own;
  logic             w_drop;
  logic             w_expire;
  logic             w_rel;
  logic             w_take;

  assign w_own    = (r_state == OWN);
  assign w_drop   = ~req[r_sel];
  assign w_expire = (r_hold_cnt == LAST);
  assign w_rel    = w_own & (w_drop | w_expire);
  assign w_take   = w_found & (~w_own | w_rel);

  // An expiring owner is searched last, so it is
  // only re-granted when nobody else is asking.
  assign w_start = w_own ? r_sel + SEL_W'(1) : r_ptr;

  rr_pick u_pick (
    .req   (req),
    .start (w_start),
    .idx   (w_idx),
    .found (w_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_sel      <= '0;
      r_hold_cnt <= '0;
      r_grant    <= '0;
      r_valid    <= 1'b0;
      r_exp      <= 1'b0;
    end else begin
      r_exp <= w_rel & w_expire;
      if (w_take) begin
        r_state    <= OWN;
        r_sel      <= w_idx;
        r_grant    <= sel2onehot(w_idx);
        r_valid    <= 1'b1;
        r_hold_cnt <= '0;
        r_ptr      <= w_idx + SEL_W'(1);
      end else if (w_rel) begin
        r_state    <= IDLE;
        r_sel      <= '0;
        r_grant    <= '0;
        r_valid    <= 1'b0;
        r_hold_cnt <= '0;
      end else if (w_own) begin
        r_hold_cnt <= r_hold_cnt + CW'(1);
      end
    end
  end

  assign grant        = r_grant;
  assign bus_sel      = r_sel;
  assign bus_valid    = r_valid;
  assign hold_expired = r_exp;

endmodule

// File: tb/tb_common_bus_arbiter.sv
// Bench for common_bus_arbiter: directed vectors plus random
// traffic against an abstract ownership model, MAX_HOLD 4/2/1.
module tb_common_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;

  logic [7:0] g [3];
  logic [2:0] s [3];
  logic       v [3];
  logic       e [3];

  int n_chk;
  int n_fail;

  common_bus_arbiter #(.MAX_HOLD(4)) u4 (
    .clk(clk), .rst(rst), .req(req),
    .grant(g[0]), .bus_sel(s[0]),
    .bus_valid(v[0]), .hold_expired(e[0])
  );

  common_bus_arbiter #(.MAX_HOLD(2)) u2 (
    .clk(clk), .rst(rst), .req(req),
    .grant(g[1]), .bus_sel(s[1]),
    .bus_valid(v[1]), .hold_expired(e[1])
  );

  common_bus_arbiter #(.MAX_HOLD(1)) u1 (
    .clk(clk), .rst(rst), .req(req),
    .grant(g[2]), .bus_sel(s[2]),
    .bus_valid(v[2]), .hold_expired(e[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Abstract model: owner index (-1 = idle), cycles held, pointer.
  typedef struct {
    int owner;
    int held;
    int ptr;
    bit exp;
  } model_t;

  model_t m [3];
  int     mh [3];

  function automatic int search(logic [7:0] r, int from);
    for (int i = 0; i < 8; i++) begin
      if (r[(from + i) % 8]) return (from + i) % 8;
    end
    return -1;
  endfunction

  function automatic model_t step(model_t c, logic [7:0] r,
                                  bit rs, int lim);
    model_t n;
    int w;
    n = c;
    n.exp = 1'b0;
    if (rs) begin
      n = '{owner: -1, held: 0, ptr: 0, exp: 1'b0};
    end else if (c.owner < 0) begin
      w = search(r, c.ptr);
      if (w >= 0) n = '{owner: w, held: 0, ptr: (w + 1) % 8, exp: 1'b0};
    end else if (r[c.owner] && (c.held + 1 < lim)) begin
      n.held = c.held + 1;
    end else begin
      n.exp = (c.held + 1 >= lim);
      w = search(r, (c.owner + 1) % 8);
      if (w >= 0) n = '{owner: w, held: 0, ptr: (w + 1) % 8, exp: n.exp};
      else begin
        n.owner = -1;
        n.held = 0;
      end
    end
    return n;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    logic [7:0] eg;
    int es;
    @(posedge clk);
    for (int k = 0; k < 3; k++) m[k] = step(m[k], req, rst, mh[k]);
    #1;
    for (int k = 0; k < 3; k++) begin
      eg = (m[k].owner >= 0) ? 8'(1 << m[k].owner) : 8'h00;
      es = (m[k].owner >= 0) ? m[k].owner : 0;
      chk($sformatf("mh%0d grant", mh[k]), 32'(g[k]), 32'(eg));
      chk($sformatf("mh%0d sel", mh[k]), 32'(s[k]), 32'(es));
      chk($sformatf("mh%0d valid", mh[k]), 32'(v[k]),
          32'(m[k].owner >= 0));
      chk($sformatf("mh%0d expired", mh[k]), 32'(e[k]),
          32'(m[k].exp));
    end
  endtask

  typedef struct {
    bit         r;
    logic [7:0] q;
    logic [7:0] g;
    logic [2:0] s;
    bit         v;
    bit         x;
  } vec_t;

  vec_t tbl [29];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    mh[0] = 4;
    mh[1] = 2;
    mh[2] = 1;
    for (int k = 0; k < 3; k++)
      m[k] = '{owner: -1, held: 0, ptr: 0, exp: 1'b0};
    rst = 1'b1;
    req = 8'h00;

    // Directed vectors for the MAX_HOLD=4 instance.
    tbl[0]  = '{1, 8'h00, 8'h00, 3'd0, 0, 0};
    tbl[1]  = '{1, 8'h00, 8'h00, 3'd0, 0, 0};
    tbl[2]  = '{0, 8'h00, 8'h00, 3'd0, 0, 0};
    tbl[3]  = '{0, 8'h10, 8'h10, 3'd4, 1, 0};
    tbl[4]  = '{0, 8'h10, 8'h10, 3'd4, 1, 0};
    tbl[5]  = '{0, 8'h10, 8'h10, 3'd4, 1, 0};
    tbl[6]  = '{0, 8'h00, 8'h00, 3'd0, 0, 0};
    tbl[7]  = '{1, 8'h00, 8'h00, 3'd0, 0, 0};
    tbl[8]  = '{0, 8'h81, 8'h01, 3'd0, 1, 0};
    tbl[9]  = '{0, 8'h81, 8'h01, 3'd0, 1, 0};
    tbl[10] = '{0, 8'h81, 8'h01, 3'd0, 1, 0};
    tbl[11] = '{0, 8'h81, 8'h01, 3'd0, 1, 0};
    tbl[12] = '{0, 8'h81, 8'h80, 3'd7, 1, 1};
    tbl[13] = '{0, 8'h81, 8'h80, 3'd7, 1, 0};
    tbl[14] = '{0, 8'h81, 8'h80, 3'd7, 1, 0};
    tbl[15] = '{0, 8'h81, 8'h80, 3'd7, 1, 0};
    tbl[16] = '{0, 8'h81, 8'h01, 3'd0, 1, 1};
    tbl[17] = '{0, 8'h81, 8'h01, 3'd0, 1, 0};
    tbl[18] = '{1, 8'h00, 8'h00, 3'd0, 0, 0};
    tbl[19] = '{0, 8'h24, 8'h04, 3'd2, 1, 0};
    tbl[20] = '{0, 8'h24, 8'h04, 3'd2, 1, 0};
    tbl[21] = '{0, 8'h20, 8'h20, 3'd5, 1, 0};
    tbl[22] = '{0, 8'h20, 8'h20, 3'd5, 1, 0};
    tbl[23] = '{0, 8'h40, 8'h40, 3'd6, 1, 0};
    tbl[24] = '{1, 8'hFF, 8'h00, 3'd0, 0, 0};
    tbl[25] = '{0, 8'hFF, 8'h01, 3'd0, 1, 0};
    tbl[26] = '{0, 8'hFF, 8'h01, 3'd0, 1, 0};
    tbl[27] = '{0, 8'h00, 8'h00, 3'd0, 0, 0};
    tbl[28] = '{0, 8'h00, 8'h00, 3'd0, 0, 0};

    for (int i = 0; i < 29; i++) begin
      rst = tbl[i].r;
      req = tbl[i].q;
      tick();
      chk($sformatf("tbl%0d grant", i), 32'(g[0]), 32'(tbl[i].g));
      chk($sformatf("tbl%0d sel", i), 32'(s[0]), 32'(tbl[i].s));
      chk($sformatf("tbl%0d valid", i), 32'(v[0]), 32'(tbl[i].v));
      chk($sformatf("tbl%0d exp", i), 32'(e[0]), 32'(tbl[i].x));
    end

    // Sole requester timeout, MAX_HOLD=2 and MAX_HOLD=1.
    rst = 1'b1;
    req = 8'h00;
    tick();
    rst = 1'b0;
    req = 8'h08;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("solo2 grant %0d", k), 32'(g[1]), 32'h08);
      chk($sformatf("solo2 exp %0d", k), 32'(e[1]),
          32'(k == 2 || k == 4));
      chk($sformatf("solo1 grant %0d", k), 32'(g[2]), 32'h08);
      chk($sformatf("solo1 exp %0d", k), 32'(e[2]), 32'(k > 0));
    end

    // MAX_HOLD=1 alternates every cycle between two requesters.
    rst = 1'b1;
    req = 8'h00;
    tick();
    rst = 1'b0;
    req = 8'h81;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("alt1 grant %0d", k), 32'(g[2]),
          (k % 2 == 0) ? 32'h01 : 32'h80);
      chk($sformatf("alt1 exp %0d", k), 32'(e[2]), 32'(k > 0));
    end

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(63) == 0);
      if ($urandom_range(3) == 0) begin
        req = 8'($urandom) & 8'($urandom);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/common_bus_arbiter.md
# common_bus_arbiter

Round-robin arbiter that shares the 8-source common bus among requesters. Samples eight request lines, grants exactly one source at a time, and presents the winner as a 3-bit bus select code plus a matching one-hot grant vector. A hold limit stops any single source from owning the bus indefinitely. Sits between the source register/memory control logic and the bus multiplexer select inputs.

## Interface
- MAX_HOLD, default 4: maximum consecutive cycles one grant lasts; legal range 1..16.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  8  request per source; bit i = bus source code i; level-sensitive, held while the source wants the bus.
- grant  out  8  one-hot grant, registered; all zero when the bus is idle.
- bus_sel  out  3  binary code of the current owner; drives the bus multiplexer select.
- bus_valid  out  1  high while a grant is active; equals |grant.
- hold_expired  out  1  one-cycle pulse on the edge where a grant ends because MAX_HOLD was reached.

## Operation
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: grant=0, bus_sel=0, bus_valid=0, hold_expired=0, round-robin pointer ptr=0, hold_cnt=0, state IDLE.
- States:
  - IDLE: no owner.
  - OWN: one owner.
- IDLE -> OWN: when req != 0. The winner is the first set bit of req, searching upward from ptr and wrapping 7 -> 0.
- OWN -> OWN, same owner, hold_cnt+1: when req[owner]=1 and hold_cnt < MAX_HOLD-1.
- Release: the owner ends on the first edge where req[owner]=0 or hold_cnt = MAX_HOLD-1.
  - On release, if any other req bit is set, or req[owner] is still set on expiry, the next winner is granted on the same edge. There is no idle bubble.
  - Otherwise the state goes to IDLE.
- Round-robin search on release: starts at owner+1 mod 8. A timed-out owner that is the sole requester is re-granted, with hold_cnt reset to 0 and hold_expired still pulsing.
- Pointer update: on every new grant, ptr <= winner+1 mod 8, using 3-bit wrap arithmetic. hold_cnt resets to 0 on every new grant.
- Output consistency: grant is always the one-hot decode of bus_sel when bus_valid=1, and is all zero otherwise. Two grant bits are never set at once.
- rst asserted mid-grant: all outputs and state return to reset values on that edge, regardless of req.
- MAX_HOLD=1: every grant lasts exactly one cycle, and arbitration repeats each cycle.

## Timing
- Request-to-grant latency from IDLE: 1 cycle. req rises before edge N; grant is visible after edge N.
- Release latency: owner drops req before edge N; grant drops, or hands off, at edge N. During that one cycle grant is still high with req low, and the source must not drive the bus.
- Maximum continuous ownership: MAX_HOLD cycles.
- Worst-case wait for a continuously requesting source: 7 × MAX_HOLD cycles.
- hold_expired is high for exactly the cycle following the expiring edge, coincident with the new grant.
- All outputs are registered. There is no combinational path from req to any output.

## Structure
- Shared package common_bus_pkg holds:
  - N_SRC=8 and SEL_W=3.
  - The state enum {IDLE, OWN}.
  - The select-code constants for each bus source.
- One sub-module, rr_pick, is a combinational round-robin picker:
  - Inputs: req[7:0], start[2:0].
  - Outputs: idx[2:0], found.
  - Instantiated once. The top level chooses start as ptr in IDLE or owner+1 in OWN.
- The top level holds the FSM, hold_cnt ($clog2(MAX_HOLD)+1 bits), ptr, and the output registers.

## Test plan
- Reset then idle: rst high for 2 cycles, req=0x00 -> grant=0x00, bus_sel=0, bus_valid=0 throughout.
- Single request: req=0x10 from cycle 3 to cycle 5, dropped at cycle 6 -> grant=0x10 and bus_sel=4 one cycle after req rises; grant=0 one cycle after req drops.
- Round-robin: req=0x81 held, MAX_HOLD=4 -> grants alternate 0x01 (4 cycles), 0x80 (4 cycles), 0x01, and so on; hold_expired pulses at each switch; no idle cycle between grants.
- Handoff on drop: owner 2 holds, req=0x24, source 2 drops after 2 cycles -> grant moves 0x04 -> 0x20 on the same edge; bus_sel 2 -> 5; hold_expired=0.
- Sole requester timeout, MAX_HOLD=2: req=0x08 held 6 cycles -> grant=0x08 continuous, hold_expired pulses every 2 cycles.
- Reset mid-grant: grant=0x40 active, rst pulsed for 1 cycle while req=0xFF -> outputs zero after that edge. After rst drops, grant=0x01, because ptr was reset to 0.
